// File: rtl/pl_dmem_pkg.sv
// Shared types and constants for the pipelined-CPU data memory arbiter.
// Indices address the 32-word data RAM with word index addr[6:2].
package pl_dmem_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_C    = 2'd1,
    RSP_L    = 2'd2
  } rsp_e;

  localparam int DMEM_WORDS  = 32;
  localparam int DMEM_IDX_LO = 2;
  localparam int DMEM_IDX_W  = $clog2(DMEM_WORDS);

  // Width needed to hold 0..max_v inclusive (at least one bit).
  function automatic int age_width(input int max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/pl_dmem_age_ctr.sv
// Saturating aging counter: counts consecutive cycles the loader waits,
// sat flags that the loader must win the next arbitration.
module pl_dmem_age_ctr
  import pl_dmem_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam int W = age_width(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] age_q;
  logic [W-1:0] age_d;

  always_comb begin
    age_d = age_q;
    if (clr) begin
      age_d = '0;
    end else if (inc && (age_q != MAX_V)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign sat = (age_q == MAX_V);

endmodule

// File: rtl/pl_dmem_arbiter.sv
// Two-port arbiter for the CPU data RAM: CPU MEM stage (C) vs debug/loader (L),
// one access per cycle, responses returned exactly one cycle after the grant.
module pl_dmem_arbiter
  import pl_dmem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_lock,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  output logic          m_we,
  input  logic [DW-1:0] m_dout
);

  logic    l_force;
  logic    age_sat;
  logic    c_gnt;
  logic    l_gnt;
  logic    age_clr;
  logic    age_inc;
  rsp_e    rsp_q;
  rsp_e    rsp_d;
  logic [DW-1:0] c_rdata_q;
  logic [DW-1:0] c_rdata_d;
  logic [DW-1:0] l_rdata_q;
  logic [DW-1:0] l_rdata_d;
  logic    c_rsp;
  logic    l_rsp;

  // Locked bursts and a starved loader pre-empt the CPU; otherwise CPU first.
  always_comb begin
    l_force = l_req & (l_lock | age_sat);
    c_gnt   = 1'b0;
    l_gnt   = 1'b0;
    if (!reset) begin
      if (l_force) begin
        l_gnt = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end
    end
  end

  assign age_clr = l_gnt | ~l_req;
  assign age_inc = l_req & ~l_gnt;

  pl_dmem_age_ctr #(
    .MAX (STARVE_MAX)
  ) u_age (
    .clock (clock),
    .reset (reset),
    .clr   (age_clr),
    .inc   (age_inc),
    .sat   (age_sat)
  );

  always_comb begin
    m_addr = '0;
    m_din  = '0;
    m_we   = 1'b0;
    if (c_gnt) begin
      m_addr = c_addr;
      m_din  = c_wdata;
      m_we   = c_we;
    end else if (l_gnt) begin
      m_addr = l_addr;
      m_din  = l_wdata;
      m_we   = l_we;
    end
  end

  assign c_stall = c_req & ~c_gnt;

  always_comb begin
    rsp_d = RSP_NONE;
    if (c_gnt) begin
      rsp_d = RSP_C;
    end else if (l_gnt) begin
      rsp_d = RSP_L;
    end
  end

  // A response still in flight when reset arrives is suppressed, not delivered.
  assign c_rsp = ~reset & (rsp_q == RSP_C);
  assign l_rsp = ~reset & (rsp_q == RSP_L);

  always_comb begin
    c_rdata_d = c_rsp ? m_dout : c_rdata_q;
    l_rdata_d = l_rsp ? m_dout : l_rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_q     <= RSP_NONE;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      rsp_q     <= rsp_d;
      c_rdata_q <= c_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  assign c_rvalid = c_rsp;
  assign l_ack    = l_rsp;
  assign c_rdata  = reset ? '0 : c_rdata_d;
  assign l_rdata  = reset ? '0 : l_rdata_d;

endmodule

// File: tb/tb_pl_dmem_arbiter.sv
// Scoreboard bench for pl_dmem_arbiter with a behavioural 32-word RAM and
// an arbitration reference model built from the priority/aging rules.
module tb_pl_dmem_arbiter;

  localparam int SM = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        c_stall, c_rvalid;
  logic [31:0] c_rdata;
  logic        l_req = 1'b0, l_lock = 1'b0, l_we = 1'b0;
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic        l_ack;
  logic [31:0] l_rdata;
  logic [31:0] m_addr, m_din, m_dout;
  logic        m_we;

  pl_dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_lock(l_lock), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata),
    .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_dout(m_dout)
  );

  always #5 clock = ~clock;

  // Data RAM: synchronous, output valid the cycle after the access.
  logic [31:0] ram [0:31];
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'h0;
    m_dout = 32'h0;
  end
  always @(posedge clock) begin
    if (m_we) ram[m_addr[6:2]] <= m_din;
    m_dout <= m_we ? m_din : ram[m_addr[6:2]];
  end

  typedef struct {
    logic        stall;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mdin;
    logic        rst;
  } cyc_t;

  typedef struct {
    logic        is_l;
    logic [31:0] data;
    int          due;
  } rsp_t;

  cyc_t cq[$];
  rsp_t rq[$];
  logic [31:0] mem_model [0:31];
  int   age_model = 0;
  int   cyc = 0;
  bit   done = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record what the spec rules predict for it.
  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic lr, input logic ll, input logic lw, input logic [31:0] la,
                      input logic [31:0] ld, input logic rs);
    cyc_t e;
    rsp_t r;
    logic cg, lg;
    @(posedge clock);
    #1;
    reset = rs; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    l_req = lr; l_lock = ll; l_we = lw; l_addr = la; l_wdata = ld;
    e = '{stall: cr, mwe: 1'b0, maddr: 32'h0, mdin: 32'h0, rst: rs};
    cg = 1'b0; lg = 1'b0;
    if (rs) begin
      age_model = 0;
      rq.delete();
    end else begin
      if (lr && (ll || age_model == SM)) lg = 1'b1;
      else if (cr) cg = 1'b1;
      else if (lr) lg = 1'b1;
      if (lg || !lr) age_model = 0;
      else if (age_model < SM) age_model++;
      e.stall = cr && !cg;
      if (cg || lg) begin
        e.mwe   = cg ? cw : lw;
        e.maddr = cg ? ca : la;
        e.mdin  = cg ? cd : ld;
        r.is_l  = lg;
        r.due   = cyc + 1;
        if (e.mwe) begin
          mem_model[e.maddr[6:2]] = e.mdin;
          r.data = e.mdin;
        end else begin
          r.data = mem_model[e.maddr[6:2]];
        end
        rq.push_back(r);
      end
    end
    cq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: all comparisons happen here, half a cycle after stimulus.
  initial begin
    cyc_t ce;
    rsp_t r;
    logic [31:0] hold_c, hold_l;
    hold_c = 32'h0;
    hold_l = 32'h0;
    forever begin
      @(negedge clock);
      if (done) break;
      if (cq.size() == 0) continue;
      ce = cq.pop_front();
      chk("c_stall", {31'h0, c_stall}, {31'h0, ce.stall});
      chk("m_we", {31'h0, m_we}, {31'h0, ce.mwe});
      chk("m_addr", m_addr, ce.maddr);
      chk("m_din", m_din, ce.mdin);
      if (ce.rst) begin
        hold_c = 32'h0;
        hold_l = 32'h0;
        chk("rst_c_rvalid", {31'h0, c_rvalid}, 32'h0);
        chk("rst_l_ack", {31'h0, l_ack}, 32'h0);
        chk("rst_c_rdata", c_rdata, 32'h0);
        chk("rst_l_rdata", l_rdata, 32'h0);
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        chk("rsp_due", r.due, cyc);
        chk("c_rvalid", {31'h0, c_rvalid}, {31'h0, !r.is_l});
        chk("l_ack", {31'h0, l_ack}, {31'h0, r.is_l});
        if (r.is_l) begin
          chk("l_rdata", l_rdata, r.data);
          chk("c_rdata_hold", c_rdata, hold_c);
          hold_l = r.data;
        end else begin
          chk("c_rdata", c_rdata, r.data);
          chk("l_rdata_hold", l_rdata, hold_l);
          hold_c = r.data;
        end
        $display("rsp cyc=%0d port=%s data=%h", cyc, r.is_l ? "L" : "C", r.data);
      end else begin
        chk("c_rvalid_idle", {31'h0, c_rvalid}, 32'h0);
        chk("l_ack_idle", {31'h0, l_ack}, 32'h0);
        chk("c_rdata_hold", c_rdata, hold_c);
        chk("l_rdata_hold", l_rdata, hold_l);
      end
    end
    chk("rq_drain", rq.size(), 0);
    chk("cq_drain", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    for (int i = 0; i < 32; i++) mem_model[i] = 32'h0;
    // Reset held with both requesters active.
    for (int i = 0; i < 3; i++) step(1, 0, 32'h4, 0, 1, 0, 0, 32'h8, 0, 1);
    idle(2);
    // CPU store then load at the same word.
    step(1, 1, 32'h14, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h14, 32'h0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Continuous contention: aging lets L in every fifth cycle.
    for (int i = 0; i < 12; i++)
      step(1, 0, 32'(i * 4), 0, 1, 0, 0, 32'h14, 0, 0);
    idle(1);
    // Locked loader burst of writes while the CPU waits.
    for (int i = 0; i < 8; i++)
      step(1, 0, 32'h1C, 0, 1, 1, 1, 32'(i * 4), 32'hA500_0000 + 32'(i), 0);
    step(1, 0, 32'h1C, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Lock without a request has no effect on the CPU.
    step(1, 0, 32'h10, 0, 0, 1, 0, 0, 0, 0);
    // Back-to-back CPU loads.
    step(1, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h04, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h08, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Reset the cycle after an L read grant: its response is dropped.
    step(0, 0, 0, 0, 1, 0, 0, 32'h14, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ca, la;
      ca = $urandom & 32'hFFFF_FFFC;
      la = $urandom & 32'hFFFF_FFFC;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ca, $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           la, $urandom, ($urandom_range(0, 99) == 0));
    end
    idle(3);
    @(posedge clock);
    done = 1;
  end

endmodule
